conv_img_fetch_ctrl: RTL and testbench

- Image-side controller for the BRAM shift-register convolution datapath. It sweeps output rows and issues per-bank image BRAM reads, one full image column (FILTER_L rows × IMG_D channels) per cycle.
- It drives the datapath's img_data_in, dpath_wren, dpath_sum_en, dpath_rotation_offset and dpath_result_wraddr, all aligned to BRAM read latency.
- It consumes the datapath's last_val to finish with a start/busy/done handshake.
- Stride is 1 in both dimensions.

---
 rtl/conv_img_fetch_ctrl_if.sv | 42 ++++
 rtl/conv_img_fetch_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_conv_img_fetch_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_img_fetch_ctrl_if.sv
// Bus bundle between the image fetch controller and its surroundings:
// start/busy/done handshake, image BRAM read port and datapath control.
interface conv_img_fetch_ctrl_if #(
   parameter int DATA_WIDTH = 12,
   parameter int IMG_W      = 16,
   parameter int IMG_H      = 16,
   parameter int IMG_D      = 32,
   parameter int FILTER_L   = 3
);
   localparam int RESULT_W              = IMG_W - FILTER_L + 1;
   localparam int RESULT_H              = IMG_H - FILTER_L + 1;
   localparam int BANK_ADDR_WIDTH       = $clog2(((IMG_H + FILTER_L - 1) / FILTER_L) * IMG_W);
   localparam int FILTER_L_ADDR_WIDTH   = $clog2(FILTER_L);
   localparam int RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W * RESULT_H);

   logic                                     start;
   logic                                     busy;
   logic                                     done;
   logic                                     img_ram_rden;
   logic [FILTER_L*BANK_ADDR_WIDTH-1:0]      img_ram_rdaddr;
   logic [DATA_WIDTH*IMG_D*FILTER_L-1:0]     img_ram_rdata;
   logic [DATA_WIDTH*IMG_D*FILTER_L-1:0]     img_data_in;
   logic                                     dpath_wren;
   logic                                     dpath_sum_en;
   logic [FILTER_L_ADDR_WIDTH-1:0]           dpath_rotation_offset;
   logic [RESULT_RAM_ADDR_WIDTH-1:0]         dpath_result_wraddr;
   logic                                     last_val;

   // Controller side
   modport master (
      input  start, img_ram_rdata, last_val,
      output busy, done, img_ram_rden, img_ram_rdaddr, img_data_in,
             dpath_wren, dpath_sum_en, dpath_rotation_offset, dpath_result_wraddr
   );

   // Environment side (BRAM banks, datapath, host)
   modport slave (
      output start, img_ram_rdata, last_val,
      input  busy, done, img_ram_rden, img_ram_rdaddr, img_data_in,
             dpath_wren, dpath_sum_en, dpath_rotation_offset, dpath_result_wraddr
   );
endinterface

// File: rtl/conv_img_fetch_ctrl.sv
// Image-side controller for the BRAM shift-register convolution datapath.
// Sweeps output rows, reads one full image column per cycle from the
// FILTER_L row banks, and delays the datapath control by the BRAM latency
// so it lines up with the returning pixel data.
module conv_img_fetch_ctrl #(
   parameter int DATA_WIDTH = 12,
   parameter int IMG_W      = 16,
   parameter int IMG_H      = 16,
   parameter int IMG_D      = 32,
   parameter int FILTER_L   = 3,
   parameter int RAM_LAT    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   conv_img_fetch_ctrl_if.master bus
);

   localparam int RESULT_W              = IMG_W - FILTER_L + 1;
   localparam int RESULT_H              = IMG_H - FILTER_L + 1;
   localparam int BANK_ADDR_WIDTH       = $clog2(((IMG_H + FILTER_L - 1) / FILTER_L) * IMG_W);
   localparam int FILTER_L_ADDR_WIDTH   = $clog2(FILTER_L);
   localparam int RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W * RESULT_H);
   localparam int COL_W                 = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W                 = (RESULT_H > 1) ? $clog2(RESULT_H) : 1;
   localparam int BA                    = BANK_ADDR_WIDTH;
   localparam int FA                    = FILTER_L_ADDR_WIDTH;
   localparam int RA                    = RESULT_RAM_ADDR_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   state_t                                r_state;
   state_t                                w_state_nxt;
   logic                                  w_rden;
   logic                                  w_busy;
   logic                                  w_done;
   logic                                  w_last_col;
   logic                                  w_last_row;

   // Sweep position; r_row_mod / r_row_blk / r_row_base track r%FILTER_L,
   // r/FILTER_L and r*RESULT_W incrementally so no divider is needed.
   logic [ROW_W-1:0]                      r_row;
   logic [COL_W-1:0]                      r_col;
   logic [FA-1:0]                         r_row_mod;
   logic [BA-1:0]                         r_row_blk;
   logic [RA-1:0]                         r_row_base;

   logic [FILTER_L*BA-1:0]                w_rdaddr;
   logic [BA-1:0]                         w_blk;
   logic                                  w_sum_en_p0;
   logic [RA-1:0]                         w_wraddr_p0;
   logic [DATA_WIDTH*IMG_D*FILTER_L-1:0]  w_img_data;

   logic                                  r_vld_p   [RAM_LAT];
   logic                                  r_sum_p   [RAM_LAT];
   logic [FA-1:0]                         r_off_p   [RAM_LAT];
   logic [RA-1:0]                         r_wra_p   [RAM_LAT];

   assign w_last_col = (r_col == COL_W'(IMG_W - 1));
   assign w_last_row = (r_row == ROW_W'(RESULT_H - 1));

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // FSM next state and handshake outputs; last_val is honoured on the final
   // issue cycle too, so a datapath that finishes immediately is not missed
   always_comb begin
      w_state_nxt = r_state;
      w_rden      = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            w_rden = 1'b1;
            w_busy = 1'b1;
            if (w_last_col && w_last_row) w_state_nxt = bus.last_val ? S_DONE : S_DRAIN;
         end
         S_DRAIN: begin
            w_busy = 1'b1;
            if (bus.last_val) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Column/row sweep counters; cleared on start and after the final issue
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_row      <= '0;
         r_col      <= '0;
         r_row_mod  <= '0;
         r_row_blk  <= '0;
         r_row_base <= '0;
      end else if (r_state == S_IDLE && bus.start) begin
         r_row      <= '0;
         r_col      <= '0;
         r_row_mod  <= '0;
         r_row_blk  <= '0;
         r_row_base <= '0;
      end else if (r_state == S_FETCH) begin
         if (!w_last_col) begin
            r_col <= r_col + COL_W'(1);
         end else if (w_last_row) begin
            r_row      <= '0;
            r_col      <= '0;
            r_row_mod  <= '0;
            r_row_blk  <= '0;
            r_row_base <= '0;
         end else begin
            r_col      <= '0;
            r_row      <= r_row + ROW_W'(1);
            r_row_base <= r_row_base + RA'(RESULT_W);
            if (r_row_mod == FA'(FILTER_L - 1)) begin
               r_row_mod <= '0;
               r_row_blk <= r_row_blk + BA'(1);
            end else begin
               r_row_mod <= r_row_mod + FA'(1);
            end
         end
      end
   end

   // Per-bank read address: window rows in banks below r%FILTER_L belong to
   // the next block of FILTER_L image rows
   always_comb begin
      w_rdaddr = '0;
      w_blk    = '0;
      for (int b = 0; b < FILTER_L; b++) begin
         w_blk                     = r_row_blk + ((FA'(b) < r_row_mod) ? BA'(1) : BA'(0));
         w_rdaddr[b*BA +: BA]      = w_blk * BA'(IMG_W) + BA'(r_col);
      end
   end

   // ---- stage p0: control computed alongside the issued read ----
   assign w_sum_en_p0 = w_rden && (r_col >= COL_W'(FILTER_L - 1));
   assign w_wraddr_p0 = r_row_base + RA'(r_col) - RA'(FILTER_L - 1);

   // Delay line matching BRAM read latency; flushed by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RAM_LAT; i++) begin
            r_vld_p[i] <= 1'b0;
            r_sum_p[i] <= 1'b0;
            r_off_p[i] <= '0;
            r_wra_p[i] <= '0;
         end
      end else begin
         r_vld_p[0] <= w_rden;
         r_sum_p[0] <= w_sum_en_p0;
         r_off_p[0] <= r_row_mod;
         r_wra_p[0] <= w_wraddr_p0;
         for (int i = 1; i < RAM_LAT; i++) begin
            r_vld_p[i] <= r_vld_p[i-1];
            r_sum_p[i] <= r_sum_p[i-1];
            r_off_p[i] <= r_off_p[i-1];
            r_wra_p[i] <= r_wra_p[i-1];
         end
      end
   end

   // ---- stage p(RAM_LAT): control aligned with returning BRAM data ----
   assign w_img_data                = bus.img_ram_rdata;
   assign bus.img_data_in           = w_img_data;
   assign bus.busy                  = w_busy;
   assign bus.done                  = w_done;
   assign bus.img_ram_rden          = w_rden;
   assign bus.img_ram_rdaddr        = w_rdaddr;
   assign bus.dpath_wren            = r_vld_p[RAM_LAT-1];
   assign bus.dpath_sum_en          = r_sum_p[RAM_LAT-1];
   assign bus.dpath_rotation_offset = r_off_p[RAM_LAT-1];
   assign bus.dpath_result_wraddr   = r_wra_p[RAM_LAT-1];

endmodule

// File: tb/tb_conv_img_fetch_ctrl.sv
// Directed bench for conv_img_fetch_ctrl: full sweep at RAM_LAT=1 with
// ignored start/last_val injections, mid-sweep reset and replay, and a
// RAM_LAT=3 sweep where last_val arrives on the final issue cycle.
module tb_conv_img_fetch_ctrl;

   localparam int DW     = 12;
   localparam int IW     = 16;
   localparam int IH     = 16;
   localparam int ID     = 32;
   localparam int FL     = 3;
   localparam int BA     = 7;    // clog2(6*16)
   localparam int RA     = 8;    // clog2(14*14)
   localparam int NISSUE = 224;  // 16 columns * 14 output rows
   localparam int NRES   = 196;  // 14 * 14
   localparam int BUSW   = DW * ID * FL;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;

   conv_img_fetch_ctrl_if #(.DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH), .IMG_D(ID), .FILTER_L(FL)) ifa ();
   conv_img_fetch_ctrl_if #(.DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH), .IMG_D(ID), .FILTER_L(FL)) ifb ();

   conv_img_fetch_ctrl #(.DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH), .IMG_D(ID), .FILTER_L(FL), .RAM_LAT(1))
      dut_a (.clk(clk), .reset(rst_a), .bus(ifa));

   conv_img_fetch_ctrl #(.DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH), .IMG_D(ID), .FILTER_L(FL), .RAM_LAT(3))
      dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

   int n_cmp = 0;
   int n_err = 0;
   int n_sum;
   int exp_wr;
   logic [BUSW-1:0] rdata_v;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bank b address straight from the memory layout: the bank holds the
   // window row congruent to b mod FL
   function automatic logic [FL*BA-1:0] exp_addr(input int idx);
      logic [FL*BA-1:0] res;
      int r, c, row;
      res = '0;
      r = idx / IW;
      c = idx % IW;
      for (int b = 0; b < FL; b++) begin
         row = r + ((b - (r % FL) + FL) % FL);
         res[b*BA +: BA] = BA'((row / FL) * IW + c);
      end
      return res;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycle k counts from the start cycle (k=0); issue idx = k-1, and the
   // datapath outputs at cycle k belong to issue idx k-1-lat
   task automatic check_cycle(input int k, input int lat, input bit use_b);
      logic             rden, wren, sum;
      logic [FL*BA-1:0] addr;
      logic [1:0]       off;
      logic [RA-1:0]    wra;
      int p, pr, pc;
      rden = use_b ? ifb.img_ram_rden          : ifa.img_ram_rden;
      addr = use_b ? ifb.img_ram_rdaddr        : ifa.img_ram_rdaddr;
      wren = use_b ? ifb.dpath_wren            : ifa.dpath_wren;
      sum  = use_b ? ifb.dpath_sum_en          : ifa.dpath_sum_en;
      off  = use_b ? ifb.dpath_rotation_offset : ifa.dpath_rotation_offset;
      wra  = use_b ? ifb.dpath_result_wraddr   : ifa.dpath_result_wraddr;
      if (k >= 1 && k <= NISSUE) begin
         chk_eq($sformatf("rden@%0d", k), 64'(rden), 64'd1);
         chk_eq($sformatf("rdaddr@%0d", k), 64'(addr), 64'(exp_addr(k - 1)));
      end else begin
         chk_eq($sformatf("rden_idle@%0d", k), 64'(rden), 64'd0);
      end
      p = k - 1 - lat;
      if (p >= 0 && p < NISSUE) begin
         pr = p / IW;
         pc = p % IW;
         chk_eq($sformatf("wren@%0d", k), 64'(wren), 64'd1);
         chk_eq($sformatf("offset@%0d", k), 64'(off), 64'(pr % FL));
         chk_eq($sformatf("sum_en@%0d", k), 64'(sum), 64'(pc >= FL - 1));
         if (pc >= FL - 1) begin
            chk_eq($sformatf("wraddr@%0d", k), 64'(wra), 64'(exp_wr));
            exp_wr++;
         end
      end else begin
         chk_eq($sformatf("wren_off@%0d", k), 64'(wren), 64'd0);
         chk_eq($sformatf("sum_off@%0d", k), 64'(sum), 64'd0);
      end
      if (sum) n_sum++;
   endtask

   task automatic check_passthrough(input string tag);
      for (int i = 0; i < BUSW / 32; i++) rdata_v[i*32 +: 32] = $urandom;
      ifa.img_ram_rdata = rdata_v;
      #1;
      for (int i = 0; i < BUSW / 32; i++)
         chk_eq(tag, 64'(ifa.img_data_in[i*32 +: 32]), 64'(rdata_v[i*32 +: 32]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      ifa.start = 1'b0; ifa.last_val = 1'b0; ifa.img_ram_rdata = '0;
      ifb.start = 1'b0; ifb.last_val = 1'b0; ifb.img_ram_rdata = '0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (2) tick();

      // Reset values
      chk_eq("rst_busy",   64'(ifa.busy), 64'd0);
      chk_eq("rst_done",   64'(ifa.done), 64'd0);
      chk_eq("rst_rden",   64'(ifa.img_ram_rden), 64'd0);
      chk_eq("rst_rdaddr", 64'(ifa.img_ram_rdaddr), 64'd0);
      chk_eq("rst_wren",   64'(ifa.dpath_wren), 64'd0);
      chk_eq("rst_sum",    64'(ifa.dpath_sum_en), 64'd0);
      chk_eq("rst_off",    64'(ifa.dpath_rotation_offset), 64'd0);
      chk_eq("rst_wraddr", 64'(ifa.dpath_result_wraddr), 64'd0);
      rst_a = 1'b0;
      rst_b = 1'b0;
      tick();
      chk_eq("idle_busy", 64'(ifa.busy), 64'd0);

      // Full sweep, RAM_LAT=1, with a stray start and last_val during FETCH
      n_sum = 0; exp_wr = 0;
      ifa.start = 1'b1;
      for (int k = 1; k <= 230; k++) begin
         tick();
         ifa.start    = (k == 50);
         ifa.last_val = (k == 60) || (k == 228);
         check_cycle(k, 1, 1'b0);
         if (k <= 228) begin
            chk_eq($sformatf("busy@%0d", k), 64'(ifa.busy), 64'd1);
            chk_eq($sformatf("done@%0d", k), 64'(ifa.done), 64'd0);
         end
         if (k == 1)   chk_eq("rdaddr_first", 64'(ifa.img_ram_rdaddr), 64'd0);
         if (k == 2)   chk_eq("wren_first", 64'(ifa.dpath_wren), 64'd1);
         if (k == 22)  chk_eq("rdaddr_r1c5", 64'(ifa.img_ram_rdaddr), 64'({7'd5, 7'd5, 7'd21}));
         if (k == 23)  chk_eq("offset_r1", 64'(ifa.dpath_rotation_offset), 64'd1);
         if (k == 224) chk_eq("rdaddr_r13c15", 64'(ifa.img_ram_rdaddr), 64'({7'd79, 7'd79, 7'd95}));
         if (k == 225) begin
            chk_eq("sum_last", 64'(ifa.dpath_sum_en), 64'd1);
            chk_eq("wraddr_last", 64'(ifa.dpath_result_wraddr), 64'd195);
         end
         if (k == 229) begin
            chk_eq("done_pulse", 64'(ifa.done), 64'd1);
            chk_eq("busy_drop", 64'(ifa.busy), 64'd0);
         end
         if (k == 230) chk_eq("done_once", 64'(ifa.done), 64'd0);
         if (k == 10 || k == 200) check_passthrough($sformatf("img_data_in@%0d", k));
      end
      ifa.last_val = 1'b0;
      chk_eq("sum_count_a", 64'(n_sum), 64'(NRES));

      // Reset at issue cycle 100, then replay from r=0, c=0
      tick();
      ifa.start = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         tick();
         ifa.start = 1'b0;
      end
      rst_a = 1'b1;
      #1;
      chk_eq("mid_rst_busy",   64'(ifa.busy), 64'd0);
      chk_eq("mid_rst_rden",   64'(ifa.img_ram_rden), 64'd0);
      chk_eq("mid_rst_wren",   64'(ifa.dpath_wren), 64'd0);
      chk_eq("mid_rst_sum",    64'(ifa.dpath_sum_en), 64'd0);
      chk_eq("mid_rst_rdaddr", 64'(ifa.img_ram_rdaddr), 64'd0);
      chk_eq("mid_rst_off",    64'(ifa.dpath_rotation_offset), 64'd0);
      chk_eq("mid_rst_wraddr", 64'(ifa.dpath_result_wraddr), 64'd0);
      tick();
      rst_a = 1'b0;
      tick();
      n_sum = 0; exp_wr = 0;
      ifa.start = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         ifa.start = 1'b0;
         check_cycle(k, 1, 1'b0);
         chk_eq($sformatf("replay_busy@%0d", k), 64'(ifa.busy), 64'd1);
      end
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;

      // RAM_LAT=3 sweep; last_val on the final issue cycle must still end it
      tick();
      n_sum = 0; exp_wr = 0;
      ifb.start = 1'b1;
      for (int k = 1; k <= 228; k++) begin
         tick();
         ifb.start    = 1'b0;
         ifb.last_val = (k == 224);
         check_cycle(k, 3, 1'b1);
         if (k <= 224) chk_eq($sformatf("b_busy@%0d", k), 64'(ifb.busy), 64'd1);
         if (k == 3)   chk_eq("b_wren_lag3", 64'(ifb.dpath_wren), 64'd0);
         if (k == 4)   chk_eq("b_wren_first", 64'(ifb.dpath_wren), 64'd1);
         if (k == 225) begin
            chk_eq("b_done_pulse", 64'(ifb.done), 64'd1);
            chk_eq("b_busy_drop", 64'(ifb.busy), 64'd0);
         end
         if (k == 226) chk_eq("b_done_once", 64'(ifb.done), 64'd0);
         if (k == 227) chk_eq("b_wraddr_last", 64'(ifb.dpath_result_wraddr), 64'd195);
      end
      ifb.last_val = 1'b0;
      chk_eq("sum_count_b", 64'(n_sum), 64'(NRES));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
